// File: rtl/ofm_result_checker.sv
`default_nettype none
// ============================================================================
// Module      : ofm_result_checker
// Description : Compares an output-feature-map region in a DUT RAM against a
//               golden RAM, NUM_LANE signed elements per word, and reports a
//               mismatch count, the first mismatching element index, a
//               wrapping checksum of the DUT elements and a pass flag.
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   start                    : one-cycle run request, honoured only when idle
//   mode                     : 0 exact, 1 tolerance, 2 checksum only, 3 = 0
//   stop_on_fail             : end the run at the first failing beat
//   tol                      : unsigned tolerance for mode 1
//   dut_base, gold_base      : first word addresses of the two regions
//   length                   : element count (0 completes immediately)
//   rd_en, dut_addr,gold_addr: shared read strobe and word addresses
//   dut_data, gold_data      : read data, one cycle after rd_en
//   busy, done, pass         : run active, completion pulse, result
//   err_count                : saturating mismatch count
//   first_err_idx            : index of first mismatch, all-ones if none
//   checksum                 : wrapping sum of checked DUT elements
//
// Revision    : 1.0 - initial release
// ============================================================================
module ofm_result_checker #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_LANE   = 16,
    parameter int ADDR_WIDTH = 22,
    parameter int LEN_WIDTH  = 24,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [1:0]                     mode,
    input  logic                           stop_on_fail,
    input  logic [DATA_WIDTH-1:0]          tol,
    input  logic [ADDR_WIDTH-1:0]          dut_base,
    input  logic [ADDR_WIDTH-1:0]          gold_base,
    input  logic [LEN_WIDTH-1:0]           length,
    output logic                           rd_en,
    output logic [ADDR_WIDTH-1:0]          dut_addr,
    output logic [ADDR_WIDTH-1:0]          gold_addr,
    input  logic [NUM_LANE*DATA_WIDTH-1:0] dut_data,
    input  logic [NUM_LANE*DATA_WIDTH-1:0] gold_data,
    output logic                           busy,
    output logic                           done,
    output logic                           pass,
    output logic [CNT_WIDTH-1:0]           err_count,
    output logic [LEN_WIDTH-1:0]           first_err_idx,
    output logic [DATA_WIDTH-1:0]          checksum
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] c_mode_tol = 2'd1;
    localparam logic [1:0] c_mode_sum = 2'd2;

    localparam logic [LEN_WIDTH-1:0] c_lanes = LEN_WIDTH'(NUM_LANE);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [1:0]                r_state;
    logic [1:0]                r_mode;
    logic                      r_sof;
    logic [DATA_WIDTH-1:0]     r_tol;
    logic [LEN_WIDTH-1:0]      r_num_beats;
    logic [LEN_WIDTH-1:0]      r_last_lanes;
    logic [LEN_WIDTH-1:0]      r_issue_left;
    logic [LEN_WIDTH-1:0]      r_eval_beat;
    logic [LEN_WIDTH-1:0]      r_eval_elem;
    logic                      r_vld;
    logic                      r_seen_err;
    logic                      r_rd_en;
    logic [ADDR_WIDTH-1:0]     r_dut_addr;
    logic [ADDR_WIDTH-1:0]     r_gold_addr;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_pass;
    logic [CNT_WIDTH-1:0]      r_err_count;
    logic [LEN_WIDTH-1:0]      r_first_err_idx;
    logic [DATA_WIDTH-1:0]     r_checksum;

    // ------------------------------------------------------------------
    // Run geometry, derived from the live inputs on the start cycle
    // ------------------------------------------------------------------
    logic [LEN_WIDTH-1:0] w_rem;
    logic [LEN_WIDTH-1:0] w_num_beats;
    logic [LEN_WIDTH-1:0] w_last_lanes;

    assign w_rem        = length % c_lanes;
    assign w_num_beats  = (length / c_lanes) + LEN_WIDTH'(w_rem != '0);
    // A length that fills the final word exactly keeps every lane active.
    assign w_last_lanes = (w_rem == '0) ? c_lanes : w_rem;

    // ------------------------------------------------------------------
    // Beat evaluation
    // ------------------------------------------------------------------
    logic                  w_eval;
    logic                  w_last_beat;
    logic [NUM_LANE-1:0]   w_lane_fail;
    logic [DATA_WIDTH-1:0] w_lane_val [NUM_LANE];

    // Read data is only meaningful while a run is consuming it; data that
    // lands in DONE (after an early stop) or after reset is dropped here.
    assign w_eval      = r_vld && ((r_state == S_READ) || (r_state == S_DRAIN));
    assign w_last_beat = (r_eval_beat == (r_num_beats - LEN_WIDTH'(1)));

    for (genvar i = 0; i < NUM_LANE; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] w_d;
        logic [DATA_WIDTH-1:0] w_g;
        logic [DATA_WIDTH:0]   w_diff;
        logic [DATA_WIDTH:0]   w_mag;
        logic                  w_valid;
        logic                  w_mism;

        assign w_d = dut_data[i*DATA_WIDTH +: DATA_WIDTH];
        assign w_g = gold_data[i*DATA_WIDTH +: DATA_WIDTH];

        // Sign-extend by one bit so the difference of two signed values
        // never overflows, then take its magnitude.
        assign w_diff = {w_d[DATA_WIDTH-1], w_d} - {w_g[DATA_WIDTH-1], w_g};
        assign w_mag  = w_diff[DATA_WIDTH] ? (~w_diff + (DATA_WIDTH+1)'(1)) : w_diff;

        assign w_valid = !w_last_beat || (LEN_WIDTH'(i) < r_last_lanes);

        assign w_mism = (r_mode == c_mode_tol) ? (w_mag > {1'b0, r_tol}) :
                        (r_mode == c_mode_sum) ? 1'b0 :
                                                 (w_d != w_g);

        assign w_lane_fail[i] = w_valid && w_mism;
        assign w_lane_val[i]  = w_valid ? w_d : '0;
    end

    logic [CNT_WIDTH:0]    w_pop;
    logic [DATA_WIDTH-1:0] w_beat_sum;
    logic [LEN_WIDTH-1:0]  w_low_lane;
    logic                  w_any_fail;
    logic [CNT_WIDTH:0]    w_err_sum;
    logic [CNT_WIDTH-1:0]  w_err_next;
    logic                  w_stop;

    always_comb begin
        w_pop      = '0;
        w_beat_sum = '0;
        w_low_lane = '0;
        // Walk from the top lane down so the lowest failing lane wins.
        for (int i = NUM_LANE - 1; i >= 0; i--) begin
            w_pop      = w_pop + (CNT_WIDTH+1)'(w_lane_fail[i]);
            w_beat_sum = w_beat_sum + w_lane_val[i];
            if (w_lane_fail[i]) begin
                w_low_lane = LEN_WIDTH'(i);
            end
        end
    end

    assign w_any_fail = |w_lane_fail;
    assign w_err_sum  = {1'b0, r_err_count} + w_pop;
    assign w_err_next = w_err_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : w_err_sum[CNT_WIDTH-1:0];
    assign w_stop     = w_eval && r_sof && w_any_fail;

    // ------------------------------------------------------------------
    // Control and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_mode          <= 2'd0;
            r_sof           <= 1'b0;
            r_tol           <= '0;
            r_num_beats     <= '0;
            r_last_lanes    <= '0;
            r_issue_left    <= '0;
            r_eval_beat     <= '0;
            r_eval_elem     <= '0;
            r_vld           <= 1'b0;
            r_seen_err      <= 1'b0;
            r_rd_en         <= 1'b0;
            r_dut_addr      <= '0;
            r_gold_addr     <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
            r_err_count     <= '0;
            r_first_err_idx <= '1;
            r_checksum      <= '0;
        end else begin
            r_done <= 1'b0;
            r_vld  <= r_rd_en;

            if (w_eval) begin
                r_err_count <= w_err_next;
                r_checksum  <= r_checksum + w_beat_sum;
                r_eval_beat <= r_eval_beat + LEN_WIDTH'(1);
                r_eval_elem <= r_eval_elem + c_lanes;
                if (w_any_fail && !r_seen_err) begin
                    r_seen_err      <= 1'b1;
                    r_first_err_idx <= r_eval_elem + w_low_lane;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // Everything the run depends on is captured here so
                        // the inputs are free to change afterwards.
                        r_mode          <= (mode == 2'd3) ? 2'd0 : mode;
                        r_sof           <= stop_on_fail;
                        r_tol           <= tol;
                        r_num_beats     <= w_num_beats;
                        r_last_lanes    <= w_last_lanes;
                        r_issue_left    <= w_num_beats;
                        r_eval_beat     <= '0;
                        r_eval_elem     <= '0;
                        r_seen_err      <= 1'b0;
                        r_dut_addr      <= dut_base;
                        r_gold_addr     <= gold_base;
                        r_err_count     <= '0;
                        r_first_err_idx <= '1;
                        r_checksum      <= '0;
                        r_busy          <= 1'b1;
                        if (length == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                        end else begin
                            r_state <= S_READ;
                            r_rd_en <= 1'b1;
                            r_pass  <= 1'b0;
                        end
                    end
                end

                S_READ: begin
                    if (w_stop) begin
                        r_state <= S_DONE;
                        r_rd_en <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= 1'b0;
                    end else if (r_issue_left == LEN_WIDTH'(1)) begin
                        r_state <= S_DRAIN;
                        r_rd_en <= 1'b0;
                    end else begin
                        r_issue_left <= r_issue_left - LEN_WIDTH'(1);
                        r_dut_addr   <= r_dut_addr + ADDR_WIDTH'(1);
                        r_gold_addr  <= r_gold_addr + ADDR_WIDTH'(1);
                    end
                end

                S_DRAIN: begin
                    if (w_stop || (w_eval && w_last_beat)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == '0);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_en         = r_rd_en;
    assign dut_addr      = r_dut_addr;
    assign gold_addr     = r_gold_addr;
    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign err_count     = r_err_count;
    assign first_err_idx = r_first_err_idx;
    assign checksum      = r_checksum;

endmodule
`default_nettype wire

// File: tb/tb_ofm_result_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_ofm_result_checker
// Description : Self-checking bench for ofm_result_checker. Two behavioural
//               RAMs feed the checker; directed table entries and random runs
//               are compared against an element-by-element reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ofm_result_checker;

    localparam int DW = 64;
    localparam int NL = 16;
    localparam int AW = 22;
    localparam int LW = 24;
    localparam int CW = 16;
    localparam int WW = DW * NL;
    localparam int DEPTH = 1024;
    localparam logic [LW-1:0] NONE = {LW{1'b1}};

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    mode;
    logic          stop_on_fail;
    logic [DW-1:0] tol;
    logic [AW-1:0] dut_base, gold_base;
    logic [LW-1:0] length;
    logic          rd_en;
    logic [AW-1:0] dut_addr, gold_addr;
    logic [WW-1:0] dut_data, gold_data;
    logic          busy, done, pass;
    logic [CW-1:0] err_count;
    logic [LW-1:0] first_err_idx;
    logic [DW-1:0] checksum;

    logic [WW-1:0] dmem [DEPTH];
    logic [WW-1:0] gmem [DEPTH];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ofm_result_checker #(
        .DATA_WIDTH(DW), .NUM_LANE(NL), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .CNT_WIDTH(CW)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .stop_on_fail(stop_on_fail),
        .tol(tol), .dut_base(dut_base), .gold_base(gold_base), .length(length),
        .rd_en(rd_en), .dut_addr(dut_addr), .gold_addr(gold_addr),
        .dut_data(dut_data), .gold_data(gold_data),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_idx(first_err_idx), .checksum(checksum)
    );

    // Synchronous RAMs: data valid the cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en) begin
            dut_data  <= dmem[dut_addr[9:0]];
            gold_data <= gmem[gold_addr[9:0]];
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] elem(input logic [WW-1:0] w, input int lane);
        return w[lane*DW +: DW];
    endfunction

    // kind 0: identical contents; kind 1: dut = gold + 3 (no overflow)
    task automatic fill(input logic [AW-1:0] db, input logic [AW-1:0] gb, input int nwords, input int kind);
        for (int k = 0; k < nwords; k++) begin
            logic [AW-1:0] da, ga;
            logic [DW-1:0] g;
            da = db + AW'(k);
            ga = gb + AW'(k);
            for (int l = 0; l < NL; l++) begin
                g = {$urandom, $urandom};
                if (kind == 1) g = {g[62], g[62:0]};
                gmem[ga[9:0]][l*DW +: DW] = g;
                dmem[da[9:0]][l*DW +: DW] = (kind == 1) ? g + 64'd3 : g;
            end
        end
    endtask

    task automatic plant(input logic [AW-1:0] db, input int e, input logic [DW-1:0] delta);
        logic [AW-1:0] a;
        a = db + AW'(e / NL);
        dmem[a[9:0]][(e % NL)*DW +: DW] = dmem[a[9:0]][(e % NL)*DW +: DW] + delta;
    endtask

    // Reference model: walk the elements in order, applying the comparison
    // rules directly; an early stop cuts the run after the word holding the
    // first failure.
    task automatic model(input int len, input logic [1:0] md, input bit sof, input logic [DW-1:0] tl,
                         input logic [AW-1:0] db, input logic [AW-1:0] gb,
                         output int e_err, output logic [LW-1:0] e_first, output logic [DW-1:0] e_sum,
                         output int e_done, output int e_rd);
        int nb, stop_beat;
        bit found;
        nb = (len + NL - 1) / NL;
        stop_beat = -1;
        found = 0;
        e_err = 0;
        e_first = NONE;
        e_sum = '0;
        for (int e = 0; e < len; e++) begin
            logic [AW-1:0] da, ga;
            logic [DW-1:0] d, g;
            logic signed [DW+1:0] diff, mag, tl_s;
            bit bad;
            int b;
            b = e / NL;
            if (stop_beat >= 0 && b > stop_beat) break;
            da = db + AW'(b);
            ga = gb + AW'(b);
            d = elem(dmem[da[9:0]], e % NL);
            g = elem(gmem[ga[9:0]], e % NL);
            diff = $signed({{2{d[DW-1]}}, d}) - $signed({{2{g[DW-1]}}, g});
            mag = (diff < 0) ? -diff : diff;
            tl_s = $signed({2'b00, tl});
            if (md == 2'd1)      bad = (mag > tl_s);
            else if (md == 2'd2) bad = 0;
            else                 bad = (d != g);
            e_sum = e_sum + d;
            if (bad) begin
                e_err++;
                if (!found) begin
                    found = 1;
                    e_first = LW'(e);
                end
                if (sof && stop_beat < 0) stop_beat = b;
            end
        end
        if (e_err > 65535) e_err = 65535;
        if (len == 0)           begin e_done = 1;             e_rd = 0; end
        else if (stop_beat >= 0) begin e_done = stop_beat + 3; e_rd = (stop_beat + 2 < nb) ? stop_beat + 2 : nb; end
        else                    begin e_done = nb + 2;        e_rd = nb; end
    endtask

    // One run. Table expectations (if given) override the model for the
    // scalar results; checksum, read count and addresses come from the model.
    task automatic run(input string nm, input int len, input logic [1:0] md, input bit sof,
                       input logic [DW-1:0] tl, input logic [AW-1:0] db, input logic [AW-1:0] gb,
                       input bit poke, input bit has_tab, input int t_done, input bit t_pass,
                       input int t_err, input logic [LW-1:0] t_first);
        int m_err, m_done, m_rd, c, rdc, addr_bad;
        logic [LW-1:0] m_first;
        logic [DW-1:0] m_sum;
        model(len, md, sof, tl, db, gb, m_err, m_first, m_sum, m_done, m_rd);
        if (has_tab) begin
            m_done = t_done;
            m_err = t_err;
            m_first = t_first;
        end
        @(negedge clk);
        length = LW'(len); mode = md; stop_on_fail = sof; tol = tl;
        dut_base = db; gold_base = gb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Scramble the run inputs: the captured values must be used.
        length = LW'($urandom_range(1, 50)); mode = 2'($urandom); stop_on_fail = 1'($urandom);
        tol = {$urandom, $urandom}; dut_base = AW'($urandom); gold_base = AW'($urandom);
        c = 1; rdc = 0; addr_bad = 0;
        while (!done && c < 2000) begin
            if (rd_en) begin
                if (dut_addr !== db + AW'(rdc) || gold_addr !== gb + AW'(rdc)) addr_bad++;
                rdc++;
            end
            start = (poke && c == 3);
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        check({nm, ".done_cycle"}, 64'(c), 64'(m_done));
        check({nm, ".pass"}, 64'(pass), has_tab ? 64'(t_pass) : 64'(m_err == 0));
        check({nm, ".err_count"}, 64'(err_count), 64'(m_err));
        check({nm, ".first_err_idx"}, 64'(first_err_idx), 64'(m_first));
        check({nm, ".checksum"}, checksum, m_sum);
        check({nm, ".rd_count"}, 64'(rdc), 64'(m_rd));
        check({nm, ".addr_errors"}, 64'(addr_bad), 64'd0);
        check({nm, ".busy_at_done"}, 64'(busy), 64'd1);
        @(negedge clk);
        check({nm, ".done_pulse_width"}, 64'(done), 64'd0);
        check({nm, ".idle_after"}, 64'({busy, rd_en}), 64'd0);
        check({nm, ".err_hold"}, 64'(err_count), 64'(m_err));
    endtask

    task automatic check_reset_state(input string nm);
        check({nm, ".busy"}, 64'(busy), 64'd0);
        check({nm, ".rd_en"}, 64'(rd_en), 64'd0);
        check({nm, ".done"}, 64'(done), 64'd0);
        check({nm, ".pass"}, 64'(pass), 64'd0);
        check({nm, ".err_count"}, 64'(err_count), 64'd0);
        check({nm, ".first_err_idx"}, 64'(first_err_idx), 64'(NONE));
        check({nm, ".checksum"}, checksum, 64'd0);
        check({nm, ".addr"}, 64'({dut_addr, gold_addr}), 64'd0);
    endtask

    typedef struct {
        int            len;
        logic [1:0]    md;
        bit            sof;
        logic [DW-1:0] tl;
        int            kind;
        int            p0;
        int            p1;
        int            e_done;
        bit            e_pass;
        int            e_err;
        logic [LW-1:0] e_first;
    } vec_t;

    vec_t tab [10];

    initial begin
        tab[0] = '{8192, 2'd0, 1'b0, 64'd0, 0, -1, -1, 514, 1'b1, 0,    NONE};
        tab[1] = '{20,   2'd0, 1'b0, 64'd0, 0, 21, 17, 4,   1'b0, 1,    24'd17};
        tab[2] = '{100,  2'd1, 1'b0, 64'd3, 1, -1, -1, 9,   1'b1, 0,    NONE};
        tab[3] = '{100,  2'd1, 1'b0, 64'd2, 1, -1, -1, 9,   1'b0, 100,  24'd0};
        tab[4] = '{1024, 2'd0, 1'b1, 64'd0, 0, 40, -1, 5,   1'b0, 1,    24'd40};
        tab[5] = '{0,    2'd0, 1'b0, 64'd0, 0, -1, -1, 1,   1'b1, 0,    NONE};
        tab[6] = '{33,   2'd2, 1'b0, 64'd0, 0, 5,  32, 5,   1'b1, 0,    NONE};
        tab[7] = '{16,   2'd3, 1'b0, 64'd0, 0, 5,  -1, 3,   1'b0, 1,    24'd5};
        tab[8] = '{17,   2'd0, 1'b0, 64'd0, 1, -1, -1, 4,   1'b0, 17,   24'd0};
        tab[9] = '{40,   2'd0, 1'b1, 64'd0, 0, 39, -1, 5,   1'b0, 1,    24'd39};

        rst = 1'b1; start = 1'b0; mode = 2'd0; stop_on_fail = 1'b0; tol = '0;
        dut_base = '0; gold_base = '0; length = '0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        // Directed table; vector 0 also pulses start while busy, vector 2
        // starts just below the top of the address space to exercise wrap.
        for (int i = 0; i < 10; i++) begin
            logic [AW-1:0] db, gb;
            db = (i == 2) ? 22'h3FFFFE : AW'($urandom);
            gb = AW'($urandom);
            fill(db, gb, (tab[i].len + NL - 1) / NL + 1, tab[i].kind);
            if (tab[i].p0 >= 0) plant(db, tab[i].p0, 64'd1);
            if (tab[i].p1 >= 0) plant(db, tab[i].p1, 64'd1);
            run($sformatf("tab%0d", i), tab[i].len, tab[i].md, tab[i].sof, tab[i].tl, db, gb,
                i == 0, 1'b1, tab[i].e_done, tab[i].e_pass, tab[i].e_err, tab[i].e_first);
        end

        // Reset in the middle of a long read phase.
        begin
            logic [AW-1:0] db, gb;
            db = AW'($urandom);
            gb = AW'($urandom);
            fill(db, gb, 64, 0);
            @(negedge clk);
            length = 24'd1024; mode = 2'd0; stop_on_fail = 1'b0; dut_base = db; gold_base = gb;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (6) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check_reset_state("midrst");
            repeat (2) @(negedge clk);
            check("midrst.stays_idle", 64'({busy, rd_en, done}), 64'd0);
            fill(db, gb, 2, 0);
            plant(db, 21, 64'd1);
            plant(db, 17, 64'd1);
            run("after_rst", 20, 2'd0, 1'b0, 64'd0, db, gb, 1'b0, 1'b1, 4, 1'b0, 1, 24'd17);
        end

        // Random runs against the reference model.
        for (int r = 0; r < 24; r++) begin
            logic [AW-1:0] db, gb;
            int len, np;
            db = AW'($urandom);
            gb = AW'($urandom);
            len = (r % 4 == 0) ? 16 * $urandom_range(1, 12) : $urandom_range(0, 300);
            fill(db, gb, (len + NL - 1) / NL + 1, 0);
            np = (len > 0) ? $urandom_range(0, 4) : 0;
            for (int p = 0; p < np; p++) begin
                logic [DW-1:0] dl;
                dl = 64'($urandom_range(1, 8));
                if ($urandom_range(0, 1) == 1) dl = -dl;
                plant(db, $urandom_range(0, len - 1), dl);
            end
            run($sformatf("rnd%0d", r), len, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                64'($urandom_range(0, 6)), db, gb, 1'b0, 1'b0, 0, 1'b0, 0, NONE);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
